// File: rtl/prc_frame_copy.sv
`default_nettype none
// ============================================================================
// prc_frame_copy : bus-mastering copy of the 96x64 framebuffer into the LCD.
// Optional PRC_FRAME_COPY_INVERT_EN adds an invert input.         Rev 1.0
// ============================================================================
module prc_frame_copy #(
    parameter logic [23:0] FB_BASE       = 24'h001000,
    parameter logic [23:0] LCD_CMD_ADDR  = 24'h0020FE,
    parameter logic [23:0] LCD_DATA_ADDR = 24'h0020FF,
    parameter int          PAGES         = 8,
    parameter int          COLS          = 96
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        bus_ack,
    input  logic [7:0]  bus_data_in,
`ifdef PRC_FRAME_COPY_INVERT_EN
    input  logic        invert,
`endif
    output logic        bus_request,
    output logic [23:0] bus_address_out,
    output logic [7:0]  bus_data_out,
    output logic        read,
    output logic        write,
    output logic        busy,
    output logic        done
);

    localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        CMD_PAGE = 3'd2,
        CMD_COLH = 3'd3,
        CMD_COLL = 3'd4,
        RD       = 3'd5,
        WR       = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] page_q, page_d;
    logic [CW-1:0] col_q, col_d;
    logic          phase_q, phase_d;
    logic          active_q, active_d;
    logic          bus_request_q, bus_request_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic [23:0]   addr_q, addr_d;
    logic [7:0]    dout_q, dout_d;
    logic [7:0]    data_mask;

    // Access to drive onto the bus in the next cycle
    logic          present;
    state_t        pres_state;
    logic [PW-1:0] pres_page;
    logic [CW-1:0] pres_col;
    logic          pres_phase;

`ifdef PRC_FRAME_COPY_INVERT_EN
    logic inv_q, inv_d;
    assign data_mask = {8{inv_q}};
`else
    assign data_mask = 8'h00;
`endif

    always_comb begin
        state_d       = state_q;
        page_d        = page_q;
        col_d         = col_q;
        phase_d       = phase_q;
        active_d      = active_q;
        bus_request_d = bus_request_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        read_d        = 1'b0;
        write_d       = 1'b0;
        addr_d        = addr_q;
        dout_d        = dout_q;
        present       = 1'b0;
        pres_state    = state_q;
        pres_page     = page_q;
        pres_col      = col_q;
        pres_phase    = 1'b0;
`ifdef PRC_FRAME_COPY_INVERT_EN
        inv_d         = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = REQ;
                    busy_d        = 1'b1;
                    bus_request_d = 1'b1;
                    page_d        = '0;
                    col_d         = '0;
`ifdef PRC_FRAME_COPY_INVERT_EN
                    inv_d         = invert;
`endif
                end
            end
            REQ: begin
                if (bus_ack) begin
                    present    = 1'b1;
                    pres_state = CMD_PAGE;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (!bus_ack) begin
                    // Bus reclaimed: drop strobes, the access restarts at phase 0
                    active_d = 1'b0;
                    phase_d  = 1'b0;
                end else if (!active_q || !phase_q) begin
                    present    = 1'b1;
                    pres_phase = active_q;
                end else begin
                    present = 1'b1;
                    case (state_q)
                        CMD_PAGE: pres_state = CMD_COLH;
                        CMD_COLH: pres_state = CMD_COLL;
                        CMD_COLL: pres_state = RD;
                        RD: begin
                            pres_state = WR;
                            dout_d     = bus_data_in ^ data_mask;
                        end
                        default: begin
                            if (col_q != LAST_COL) begin
                                pres_state = RD;
                                pres_col   = col_q + 1'b1;
                            end else if (page_q != LAST_PAGE) begin
                                pres_state = CMD_PAGE;
                                pres_page  = page_q + 1'b1;
                                pres_col   = '0;
                            end else begin
                                present       = 1'b0;
                                state_d       = DONE;
                                col_d         = '0;
                                done_d        = 1'b1;
                                busy_d        = 1'b0;
                                bus_request_d = 1'b0;
                                active_d      = 1'b0;
                                phase_d       = 1'b0;
                            end
                        end
                    endcase
                end
            end
        endcase

        if (present) begin
            state_d  = pres_state;
            page_d   = pres_page;
            col_d    = pres_col;
            phase_d  = pres_phase;
            active_d = 1'b1;
            case (pres_state)
                CMD_PAGE: begin
                    addr_d  = LCD_CMD_ADDR;
                    dout_d  = 8'hB0 | 8'(pres_page);
                    write_d = ~pres_phase;
                end
                CMD_COLH: begin
                    addr_d  = LCD_CMD_ADDR;
                    dout_d  = 8'h10;
                    write_d = ~pres_phase;
                end
                CMD_COLL: begin
                    addr_d  = LCD_CMD_ADDR;
                    dout_d  = 8'h00;
                    write_d = ~pres_phase;
                end
                RD: begin
                    addr_d = FB_BASE + 24'(pres_page) * 24'(COLS) + 24'(pres_col);
                    read_d = 1'b1;
                end
                WR: begin
                    addr_d  = LCD_DATA_ADDR;
                    write_d = ~pres_phase;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            page_q        <= '0;
            col_q         <= '0;
            phase_q       <= 1'b0;
            active_q      <= 1'b0;
            bus_request_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            dout_q        <= '0;
`ifdef PRC_FRAME_COPY_INVERT_EN
            inv_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            page_q        <= page_d;
            col_q         <= col_d;
            phase_q       <= phase_d;
            active_q      <= active_d;
            bus_request_q <= bus_request_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            read_q        <= read_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
`ifdef PRC_FRAME_COPY_INVERT_EN
            inv_q         <= inv_d;
`endif
        end
    end

    assign bus_request     = bus_request_q;
    assign bus_address_out = addr_q;
    assign bus_data_out    = dout_q;
    assign read            = read_q;
    assign write           = write_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
`default_nettype wire

// File: tb/tb_prc_frame_copy.sv
`default_nettype none
// ============================================================================
// tb_prc_frame_copy : access-level model + directed and random bus stimulus.
// Rev 1.0
// ============================================================================
module tb_prc_frame_copy;

    localparam logic [23:0] FB   = 24'h001000;
    localparam logic [23:0] CMDA = 24'h0020FE;
    localparam logic [23:0] DATA = 24'h0020FF;
    localparam int NACC = 1560;
    localparam int APP  = 195;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic start = 1'b0;
    logic bus_ack = 1'b0;
    logic [7:0] bus_data_in;
`ifdef PRC_FRAME_COPY_INVERT_EN
    logic invert = 1'b0;
`endif
    logic bus_request, read, write, busy, done;
    logic [23:0] bus_address_out;
    logic [7:0] bus_data_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fb [768];
    logic [23:0] rd_off;

    always #5 clk = ~clk;

    prc_frame_copy dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .bus_ack        (bus_ack),
        .bus_data_in    (bus_data_in),
`ifdef PRC_FRAME_COPY_INVERT_EN
        .invert         (invert),
`endif
        .bus_request    (bus_request),
        .bus_address_out(bus_address_out),
        .bus_data_out   (bus_data_out),
        .read           (read),
        .write          (write),
        .busy           (busy),
        .done           (done)
    );

    // RAM slave: returns framebuffer contents for reads inside the buffer
    assign rd_off = bus_address_out - FB;
    always_comb begin
        bus_data_in = 8'hEE;
        if (read && rd_off < 24'd768) bus_data_in = fb[rd_off[9:0]];
    end

    // Access k of a frame: page k/195; slot 0..2 are commands, then read/write pairs
    function automatic logic acc_is_read(int k);
        int r = k % APP;
        return (r >= 3) && (((r - 3) % 2) == 0);
    endfunction

    function automatic logic [23:0] acc_addr(int k);
        int p = k / APP;
        int r = k % APP;
        if (r < 3) return CMDA;
        if (((r - 3) % 2) == 0) return FB + 24'(p * 96 + (r - 3) / 2);
        return DATA;
    endfunction

    function automatic logic [7:0] acc_data(int k, logic inv);
        int p = k / APP;
        int r = k % APP;
        if (r == 0) return 8'hB0 | 8'(p);
        if (r == 1) return 8'h10;
        if (r == 2) return 8'h00;
        return fb[p * 96 + (r - 3) / 2] ^ {8{inv}};
    endfunction

    // Model: 0 idle, 1 waiting for grant, 2 copying, 3 done cycle
    int          m_st = 0;
    int          m_k = 0;
    logic        m_ph = 1'b0;
    logic        m_show = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_inv = 1'b0;
    logic [23:0] m_addr = '0;
    logic [7:0]  m_dout = '0;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_st = 0; m_k = 0; m_ph = 1'b0; m_show = 1'b0; m_busy = 1'b0;
            m_done = 1'b0; m_inv = 1'b0; m_addr = '0; m_dout = '0;
        end else begin
            m_done = 1'b0;
            case (m_st)
                0: if (start) begin
                    m_st = 1;
                    m_busy = 1'b1;
`ifdef PRC_FRAME_COPY_INVERT_EN
                    m_inv = invert;
`endif
                end
                1: if (bus_ack) begin
                    m_st = 2; m_k = 0; m_ph = 1'b0; m_show = 1'b1;
                end
                2: begin
                    if (!bus_ack) begin
                        m_show = 1'b0; m_ph = 1'b0;
                    end else if (!m_show) begin
                        m_show = 1'b1; m_ph = 1'b0;
                    end else if (!m_ph) begin
                        m_ph = 1'b1;
                    end else if (m_k == NACC - 1) begin
                        m_st = 3; m_done = 1'b1; m_busy = 1'b0; m_show = 1'b0;
                    end else begin
                        m_k++; m_ph = 1'b0;
                    end
                end
                default: m_st = 0;
            endcase
            if (m_show) begin
                m_addr = acc_addr(m_k);
                if (!acc_is_read(m_k)) m_dout = acc_data(m_k, m_inv);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic        chk_en = 1'b0;
    logic [36:0] cmp_act, cmp_exp;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp_act = {bus_request, busy, done, read, write, bus_address_out, bus_data_out};
            cmp_exp = {m_busy, m_busy, m_done,
                       m_show && acc_is_read(m_k),
                       m_show && !acc_is_read(m_k) && !m_ph,
                       m_addr, m_dout};
            chk("cycle_vs_model", 64'(cmp_act), 64'(cmp_exp));
        end
    end

    int          n_dwr = 0, n_e8 = 0, n_done = 0, cyc_cnt = 0, done_cyc = -1;
    logic [23:0] last_rd = '0, p3_rd = '0;
    logic        armed = 1'b0;
    logic [31:0] wq [$];

    initial forever begin
        @(negedge clk);
        if (read) last_rd = bus_address_out;
        if (write) wq.push_back({bus_address_out, bus_data_out});
        if (write && bus_address_out == DATA) begin
            n_dwr++;
            if (last_rd == 24'h0010E8) n_e8++;
        end
        if (write && bus_address_out == CMDA && bus_data_out == 8'hB3) armed = 1'b1;
        else if (armed && read) begin
            p3_rd = bus_address_out;
            armed = 1'b0;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc_cnt;
        end
        cyc_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_dwr = 0; n_e8 = 0; n_done = 0; done_cyc = -1;
        armed = 1'b0; p3_rd = '0; wq.delete();
    endtask

    task automatic pulse_start(input logic mark);
        @(posedge clk); #1;
        start = 1'b1;
        if (mark) cyc_cnt = -1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = n_done;
        int i = 0;
        while (n_done == d0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        #1;
        chk(name, 64'(i < budget), 64'd1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 768; i++) fb[i] = 8'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 768; i++) fb[i] = 8'(i);
        #1 reset_n = 1'b0;
        chk_en = 1'b1;
        tick(3);
        chk("reset_outputs", {bus_request, busy, done, read, write, bus_address_out, bus_data_out}, 64'd0);
        reset_n = 1'b1;

        chk("model_p3_first_read", acc_addr(3 * APP + 3), 64'h001120);
        chk("model_p3_cmd", acc_data(3 * APP, 1'b0), 64'hB3);
        chk("model_p2_c40_read", acc_addr(2 * APP + 3 + 80), 64'h0010E8);
        chk("model_last_access", acc_addr(NACC - 1), 64'(DATA));

        // A: full frame with bus held, start pulsed again while busy
        for (int i = 0; i < 768; i++) fb[i] = 8'(i);
        clear_stats();
        bus_ack = 1'b1;
        pulse_start(1'b1);
        tick(500);
        pulse_start(1'b0);
        wait_done(4000, "A_done_timeout");
        tick(3);
        chk("A_data_writes", 64'(n_dwr), 64'd768);
        chk("A_done_count", 64'(n_done), 64'd1);
        chk("A_done_cycle", 64'(done_cyc), 64'd3121);
        chk("A_busy_after", 64'(busy), 64'd0);
        chk("A_total_writes", 64'(wq.size()), 64'd792);
        chk("A_p3_cmd_page", 64'(wq[297]), 64'({CMDA, 8'hB3}));
        chk("A_p3_cmd_colh", 64'(wq[298]), 64'({CMDA, 8'h10}));
        chk("A_p3_cmd_coll", 64'(wq[299]), 64'({CMDA, 8'h00}));
        chk("A_p3_first_data", 64'(wq[300]), 64'({DATA, 8'h20}));
        chk("A_p3_first_read", 64'(p3_rd), 64'h001120);

        // B: grant withheld for 20 cycles after start
        begin
            logic [23:0] addr0;
            int i;
            fill_random();
            clear_stats();
            bus_ack = 1'b0;
            addr0 = bus_address_out;
            pulse_start(1'b1);
            repeat (20) begin
                @(negedge clk);
                chk("B_req_hold", {bus_request, read, write, bus_address_out}, {37'd0, 1'b1, 2'b00, addr0});
            end
            @(posedge clk); #1;
            bus_ack = 1'b1;
            i = 0;
            do begin
                @(negedge clk);
                i++;
            end while (!write && i < 10);
            chk("B_first_cmd", {bus_address_out, bus_data_out}, 64'({CMDA, 8'hB0}));
            wait_done(4000, "B_done_timeout");
            tick(2);
            chk("B_done_count", 64'(n_done), 64'd1);
        end

        // C: grant dropped for 5 cycles during RD phase 1 at p=2 c=40
        begin
            int i;
            fill_random();
            clear_stats();
            pulse_start(1'b1);
            i = 0;
            do begin
                @(negedge clk);
                i++;
            end while (!(read && bus_address_out == 24'h0010E8) && i < 4000);
            chk("C_found_read", 64'(read && bus_address_out == 24'h0010E8), 64'd1);
            @(posedge clk); #1;
            bus_ack = 1'b0;
            tick(5);
            bus_ack = 1'b1;
            wait_done(4000, "C_done_timeout");
            tick(2);
            chk("C_data_writes", 64'(n_dwr), 64'd768);
            chk("C_e8_writes", 64'(n_e8), 64'd1);
            chk("C_done_count", 64'(n_done), 64'd1);
        end

        // D: reset mid-copy, then a clean frame
        fill_random();
        clear_stats();
        pulse_start(1'b1);
        tick(1000);
        reset_n = 1'b0;
        @(negedge clk);
        chk("D_reset_outputs", {bus_request, busy, done, read, write, bus_address_out, bus_data_out}, 64'd0);
        tick(3);
        reset_n = 1'b1;
        tick(5);
        chk("D_no_done", 64'(n_done), 64'd0);
        fill_random();
        clear_stats();
        pulse_start(1'b1);
        wait_done(4000, "D_done_timeout");
        tick(2);
        chk("D_data_writes", 64'(n_dwr), 64'd768);
        chk("D_done_count", 64'(n_done), 64'd1);

        // E: random grant and start traffic over two frames
        fill_random();
        clear_stats();
        for (int i = 0; i < 30000 && n_done < 2; i++) begin
            @(posedge clk); #1;
            bus_ack = ($urandom_range(0, 7) != 0);
            start = ($urandom_range(0, 15) == 0);
`ifdef PRC_FRAME_COPY_INVERT_EN
            invert = 1'($urandom_range(0, 1));
`endif
        end
        start = 1'b0;
        bus_ack = 1'b1;
        chk("E_two_frames", 64'(n_done >= 2), 64'd1);
        begin
            int i = 0;
            while (busy && i < 4000) begin
                @(posedge clk);
                i++;
            end
            #1;
            chk("E_drain", 64'(busy), 64'd0);
        end

`ifdef PRC_FRAME_COPY_INVERT_EN
        // F: inverted frame
        for (int i = 0; i < 768; i++) fb[i] = 8'h5A;
        clear_stats();
        invert = 1'b1;
        pulse_start(1'b1);
        invert = 1'b0;
        wait_done(4000, "F_done_timeout");
        tick(2);
        chk("F_cmd_page", 64'(wq[0]), 64'({CMDA, 8'hB0}));
        chk("F_cmd_colh", 64'(wq[1]), 64'({CMDA, 8'h10}));
        chk("F_inv_data", 64'(wq[3]), 64'({DATA, 8'hA5}));
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
